// File: rtl/rst_sync_down_timer.sv
// -----------------------------------------------------------------------------
// rst_sync_down_timer
//
// Loadable down-counting timer. It is the count-down companion of the
// free-running synchronous up counter. A start value is accepted over a
// valid/ready handshake while the timer is idle. The count then decrements
// once every PRESCALE un-paused cycles, and done pulses for one cycle on the
// terminal step. With auto_reload set, the timer restarts from the stored
// load value and produces periodic ticks.
//
// Parameters
//   WIDTH     width of count and load value
//   PRESCALE  clk cycles per decrement, legal range 1..256
//
// Ports
//   clk          clock; all logic on the rising edge
//   rst          synchronous reset, active low
//   load_valid   load request
//   load_ready   high while IDLE (decode of the state register)
//   load_value   start value, sampled on handshake
//   auto_reload  sampled at each terminal step; 1 = restart from stored value
//   pause        freezes prescaler and count while high (RUN only)
//   abort        cancels a running count without a done pulse
//   count        remaining value, registered
//   busy         high in RUN
//   done         single-cycle registered pulse on terminal step or zero load
// -----------------------------------------------------------------------------
module rst_sync_down_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   // The prescaler needs at least one bit, even when PRESCALE is 1.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state_reg  = ST_IDLE;
   logic [WIDTH-1:0] count_reg  = '0;
   logic [WIDTH-1:0] reload_reg = '0;
   logic [PW-1:0]    pre_reg    = '0;
   logic             done_reg   = 1'b0;

   logic [0:0]       state_next;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] reload_next;
   logic [PW-1:0]    pre_next;
   logic             done_next;

   logic             step;

   assign step = (pre_reg == PRE_LAST);

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      reload_next = reload_reg;
      pre_next    = pre_reg;
      done_next   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // abort and pause have no effect here; only a load moves us.
            if (load_valid) begin
               if (load_value != '0) begin
                  count_next  = load_value;
                  reload_next = load_value;
                  pre_next    = '0;
                  state_next  = ST_RUN;
               end else begin
                  // A zero load expires immediately.
                  count_next = '0;
                  done_next  = 1'b1;
               end
            end
         end

         default: begin
            if (abort) begin
               // abort wins over pause and over a coincident terminal step.
               count_next = '0;
               pre_next   = '0;
               state_next = ST_IDLE;
            end else if (!pause) begin
               if (step) begin
                  pre_next = '0;
                  if (count_reg == WIDTH'(1)) begin
                     done_next = 1'b1;
                     if (auto_reload) begin
                        // Reload directly so count never shows zero.
                        count_next = reload_reg;
                     end else begin
                        count_next = '0;
                        state_next = ST_IDLE;
                     end
                  end else begin
                     // In RUN count is never zero, so this cannot underflow.
                     count_next = count_reg - WIDTH'(1);
                  end
               end else begin
                  pre_next = pre_reg + PW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= ST_IDLE;
         count_reg  <= '0;
         reload_reg <= '0;
         pre_reg    <= '0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         reload_reg <= reload_next;
         pre_reg    <= pre_next;
         done_reg   <= done_next;
      end
   end

   assign load_ready = (state_reg == ST_IDLE);
   assign busy       = (state_reg == ST_RUN);
   assign count      = count_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_rst_sync_down_timer.sv
// -----------------------------------------------------------------------------
// tb_rst_sync_down_timer
//
// Directed bench for two timer instances: one with PRESCALE=1 and one with
// PRESCALE=4. Before each clock edge, the expected post-edge
// {count, done, busy, load_ready} of each exercised instance is pushed to
// that instance's queue. One time unit after the edge, the bench pops and
// compares it.
// -----------------------------------------------------------------------------
module tb_rst_sync_down_timer;

   typedef struct {
      string      tag;
      logic [3:0] cnt;
      logic       dn;
      logic       bsy;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // PRESCALE = 1 instance
   logic       rst1 = 1'b0, lv1 = 1'b0, ar1 = 1'b0, pa1 = 1'b0, ab1 = 1'b0;
   logic [3:0] val1 = '0;
   logic       rdy1, busy1, done1;
   logic [3:0] cnt1;

   // PRESCALE = 4 instance
   logic       rst4 = 1'b0, lv4 = 1'b0, ar4 = 1'b0, pa4 = 1'b0, ab4 = 1'b0;
   logic [3:0] val4 = '0;
   logic       rdy4, busy4, done4;
   logic [3:0] cnt4;

   rst_sync_down_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst1), .load_valid(lv1), .load_ready(rdy1),
      .load_value(val1), .auto_reload(ar1), .pause(pa1), .abort(ab1),
      .count(cnt1), .busy(busy1), .done(done1)
   );

   rst_sync_down_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst4), .load_valid(lv4), .load_ready(rdy4),
      .load_value(val4), .auto_reload(ar4), .pause(pa4), .abort(ab4),
      .count(cnt4), .busy(busy4), .done(done4)
   );

   exp_t q1[$];
   exp_t q4[$];
   int   total = 0;
   int   bad   = 0;

   task automatic push1(input string tag, input int c, input bit d, input bit b);
      exp_t e;
      e.tag = tag; e.cnt = 4'(c); e.dn = d; e.bsy = b;
      q1.push_back(e);
   endtask

   task automatic push4(input string tag, input int c, input bit d, input bit b);
      exp_t e;
      e.tag = tag; e.cnt = 4'(c); e.dn = d; e.bsy = b;
      q4.push_back(e);
   endtask

   task automatic check(input string tag, input logic [6:0] obs, input exp_t e);
      logic [6:0] req;
      // load_ready must always be the inverse of busy.
      req = {e.cnt, e.dn, e.bsy, ~e.bsy};
      total++;
      $display("txn %s cnt=%0d done=%0b busy=%0b ready=%0b", tag,
               obs[6:3], obs[2], obs[1], obs[0]);
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed cnt/done/busy/ready=%b required=%b", tag, obs, req);
      end
   endtask

   // Advance one edge, then compare each instance that has an expectation queued.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check({"p1_", e.tag}, {cnt1, done1, busy1, rdy1}, e);
      end
      if (q4.size() > 0) begin
         e = q4.pop_front();
         check({"p4_", e.tag}, {cnt4, done4, busy4, rdy4}, e);
      end
   endtask

   initial begin
      // ---------------- reset state (both instances) ----------------
      push1("reset", 0, 0, 0); push4("reset", 0, 0, 0); tick();
      push1("reset", 0, 0, 0); push4("reset", 0, 0, 0); tick();
      rst1 = 1'b1; rst4 = 1'b1;

      // ---------------- reset mid-count ----------------
      lv1 = 1'b1; val1 = 4'd9;
      push1("rstmid_load", 9, 0, 1); tick();
      lv1 = 1'b0;
      push1("rstmid_run", 8, 0, 1); tick();
      push1("rstmid_run", 7, 0, 1); tick();
      push1("rstmid_run", 6, 0, 1); tick();
      rst1 = 1'b0;
      push1("rstmid_rst", 0, 0, 0); tick();
      rst1 = 1'b1;
      push1("rstmid_after", 0, 0, 0); tick();

      // ---------------- basic count of 5 ----------------
      lv1 = 1'b1; val1 = 4'd5;
      push1("basic_load", 5, 0, 1); tick();
      lv1 = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         push1("basic_run", i, 0, 1); tick();
      end
      push1("basic_done", 0, 1, 0); tick();
      push1("basic_idle", 0, 0, 0); tick();

      // ---------------- zero load ----------------
      lv1 = 1'b1; val1 = 4'd0;
      push1("zero_load", 0, 1, 0); tick();
      lv1 = 1'b0;
      push1("zero_after", 0, 0, 0); tick();

      // ---------------- full-scale load of 15 ----------------
      lv1 = 1'b1; val1 = 4'd15;
      push1("full_load", 15, 0, 1); tick();
      lv1 = 1'b0;
      for (int i = 14; i >= 1; i--) begin
         push1("full_run", i, 0, 1); tick();
      end
      push1("full_done", 0, 1, 0); tick();
      push1("full_idle", 0, 0, 0); tick();

      // ---------------- load during RUN is ignored ----------------
      lv1 = 1'b1; val1 = 4'd3;
      push1("ign_load", 3, 0, 1); tick();
      val1 = 4'd7;     // lv1 still high while running
      push1("ign_run", 2, 0, 1); tick();
      push1("ign_run", 1, 0, 1); tick();
      lv1 = 1'b0;
      push1("ign_done", 0, 1, 0); tick();

      // ---------------- auto-reload ----------------
      ar1 = 1'b1; lv1 = 1'b1; val1 = 4'd3;
      push1("ar_load", 3, 0, 1); tick();
      lv1 = 1'b0;
      push1("ar_run", 2, 0, 1); tick();
      push1("ar_run", 1, 0, 1); tick();
      push1("ar_reload", 3, 1, 1); tick();
      push1("ar_run", 2, 0, 1); tick();
      push1("ar_run", 1, 0, 1); tick();
      push1("ar_reload", 3, 1, 1); tick();
      ar1 = 1'b0;
      push1("ar_off_run", 2, 0, 1); tick();
      push1("ar_off_run", 1, 0, 1); tick();
      push1("ar_off_done", 0, 1, 0); tick();

      // ---------------- abort on the terminal edge ----------------
      lv1 = 1'b1; val1 = 4'd2;
      push1("ab_load", 2, 0, 1); tick();
      lv1 = 1'b0;
      push1("ab_run", 1, 0, 1); tick();
      ab1 = 1'b1;
      push1("ab_term", 0, 0, 0); tick();
      // abort is ignored in IDLE: a load on the same edge is still taken
      lv1 = 1'b1; val1 = 4'd4;
      push1("ab_idle_load", 4, 0, 1); tick();
      lv1 = 1'b0; pa1 = 1'b1;
      push1("ab_over_pause", 0, 0, 0); tick();
      ab1 = 1'b0; pa1 = 1'b0;
      push1("ab_idle", 0, 0, 0); tick();

      // ---------------- pause with PRESCALE=4 ----------------
      lv4 = 1'b1; val4 = 4'd2;
      push4("ps_load", 2, 0, 1); tick();
      lv4 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         push4("ps_run", 2, 0, 1); tick();
      end
      push4("ps_step", 1, 0, 1); tick();          // edge 4
      push4("ps_run", 1, 0, 1); tick();           // edge 5
      pa4 = 1'b1;
      for (int i = 0; i < 5; i++) begin           // edges 6..10
         push4("ps_paused", 1, 0, 1); tick();
      end
      pa4 = 1'b0;
      push4("ps_run", 1, 0, 1); tick();           // edge 11
      push4("ps_run", 1, 0, 1); tick();           // edge 12
      push4("ps_done", 0, 1, 0); tick();          // edge 13
      push4("ps_idle", 0, 0, 0); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
